// File: rtl/ring_node_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_node_router                                                         |
// | Buffers alerted messages, routes them left/right/self with valid/ready.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ring_node_router #(
  parameter int width     = 32,
  parameter int ADDR_W    = 3,
  parameter int NUM_NODES = 8,
  parameter int NODE_ID   = 0,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] in_sig,
  input  logic             sig_alert,
  input  logic [1:0]       s,
  input  logic             ready_l,
  input  logic             ready_r,
  input  logic             ready_s,
  output logic [width-1:0] out_data,
  output logic             valid_l,
  output logic             valid_r,
  output logic             valid_s,
  output logic             full,
  output logic [7:0]       drop_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_D_W   = ADDR_W + 2;

  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_D_W-1:0]   c_NODES   = c_D_W'(NUM_NODES);
  localparam logic [c_D_W-1:0]   c_NODE    = c_D_W'(NODE_ID);
  localparam logic [c_D_W-1:0]   c_HALF    = c_D_W'(NUM_NODES / 2);

  localparam logic [1:0] c_RT_L = 2'd0;
  localparam logic [1:0] c_RT_R = 2'd1;
  localparam logic [1:0] c_RT_S = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [width-1:0]   r_mem_data [DEPTH];
  logic [1:0]         r_mem_rt   [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic [ADDR_W-1:0]  w_dest;
  logic [c_D_W-1:0]   w_dest_ext;
  logic [c_D_W-1:0]   w_diff_raw;
  logic [c_D_W-1:0]   w_dist;
  logic [1:0]         w_route;
  logic [1:0]         w_head_rt;
  logic [width-1:0]   w_head_data;
  logic               w_accept;
  logic               w_drop;
  logic               w_pop;
  logic               w_sel_ready;
  logic [c_CNT_W-1:0] w_count_nxt;

  assign w_dest     = in_sig[width-1 -: ADDR_W];
  assign w_dest_ext = c_D_W'(w_dest);

  // Ring distance (dest - NODE_ID) mod NUM_NODES; only consumed when dest < NUM_NODES.
  assign w_diff_raw = w_dest_ext + c_NODES - c_NODE;
  assign w_dist     = (w_diff_raw >= c_NODES) ? (w_diff_raw - c_NODES) : w_diff_raw;

  always_comb begin
    w_route = c_RT_S;
    if (w_dest_ext == c_NODE) begin
      w_route = c_RT_S;
    end else if (s == 2'b00) begin
      w_route = c_RT_R;
    end else if (s == 2'b10) begin
      w_route = c_RT_L;
    end else begin
      w_route = (w_dist <= c_HALF) ? c_RT_R : c_RT_L;
    end
  end

  // Occupancy is judged at the start of the cycle; a same-cycle pop never frees a slot.
  assign w_accept = sig_alert && (r_count < c_DEPTH) && (s != 2'b11)
                    && (w_dest_ext < c_NODES);
  assign w_drop   = sig_alert && !w_accept;

  assign w_head_data = r_mem_data[r_rptr];
  assign w_head_rt   = r_mem_rt[r_rptr];

  assign w_sel_ready = (valid_l && ready_l) || (valid_r && ready_r) || (valid_s && ready_s);
  assign w_pop       = (r_count != '0) && ((r_state == ST_IDLE) || w_sel_ready);

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_accept && w_pop) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_data[r_wptr] <= in_sig;
      r_mem_rt[r_wptr]   <= w_route;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      out_data <= '0;
      valid_l  <= 1'b0;
      valid_r  <= 1'b0;
      valid_s  <= 1'b0;
      full     <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == c_DEPTH);
      if (w_drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            out_data <= w_head_data;
            valid_l  <= (w_head_rt == c_RT_L);
            valid_r  <= (w_head_rt == c_RT_R);
            valid_s  <= (w_head_rt == c_RT_S);
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_sel_ready) begin
            if (w_pop) begin
              out_data <= w_head_data;
              valid_l  <= (w_head_rt == c_RT_L);
              valid_r  <= (w_head_rt == c_RT_R);
              valid_s  <= (w_head_rt == c_RT_S);
            end else begin
              valid_l  <= 1'b0;
              valid_r  <= 1'b0;
              valid_s  <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_node_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ring_node_router                                                      |
// | Scoreboarded random + directed bench for ring_node_router.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ring_node_router;

  localparam int W   = 32;
  localparam int AW  = 4;
  localparam int NN  = 8;
  localparam int NID = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  in_sig;
  logic          sig_alert;
  logic [1:0]    s;
  logic          ready_l;
  logic          ready_r;
  logic          ready_s;
  logic [W-1:0]  out_data;
  logic          valid_l;
  logic          valid_r;
  logic          valid_s;
  logic          full;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  ring_node_router #(
    .width(W), .ADDR_W(AW), .NUM_NODES(NN), .NODE_ID(NID), .DEPTH(DEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_sig(in_sig), .sig_alert(sig_alert), .s(s),
    .ready_l(ready_l), .ready_r(ready_r), .ready_s(ready_s),
    .out_data(out_data), .valid_l(valid_l), .valid_r(valid_r), .valid_s(valid_s),
    .full(full), .drop_cnt(drop_cnt)
  );

  // Port codes: 0 left, 1 right, 2 self.
  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   port;
  } msg_t;

  msg_t  m_fifo[$];
  msg_t  sb[$];
  msg_t  m_out;
  bit    m_has_out = 1'b0;
  int    m_drop = 0;
  bit    mon_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pvec(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [1:0] model_route(input int dest, input logic [1:0] src);
    int d;
    if (dest == NID) return 2'd2;
    if (src == 2'b00) return 2'd1;
    if (src == 2'b10) return 2'd0;
    d = (dest - NID + NN) % NN;
    return (d <= NN / 2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic port_ready(input logic [1:0] p);
    case (p)
      2'd0:    return ready_l;
      2'd1:    return ready_r;
      default: return ready_s;
    endcase
  endfunction

  // Behavioural reference: a queue of accepted messages plus one output slot.
  initial forever begin
    int   n;
    int   dest;
    bit   acc;
    msg_t e;
    @(posedge clk);
    if (!reset_n) begin
      m_fifo.delete();
      sb.delete();
      m_has_out = 1'b0;
      m_drop = 0;
    end else begin
      n = m_fifo.size();
      acc = 1'b0;
      dest = 0;
      if (sig_alert) begin
        dest = int'(in_sig[W-1 -: AW]);
        if (n < DEP && s != 2'b11 && dest < NN) acc = 1'b1;
        else if (m_drop < 255) m_drop++;
      end
      if (!m_has_out) begin
        if (n > 0) begin
          m_out = m_fifo.pop_front();
          m_has_out = 1'b1;
        end
      end else if (port_ready(m_out.port)) begin
        if (n > 0) m_out = m_fifo.pop_front();
        else m_has_out = 1'b0;
      end
      if (acc) begin
        e.data = in_sig;
        e.port = model_route(dest, s);
        m_fifo.push_back(e);
        sb.push_back(e);
      end
    end
  end

  logic [2:0] mv;
  msg_t       me;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mv = {valid_l, valid_r, valid_s};
      check("onehot", 64'($countones(mv) <= 1), 64'd1);
      check("valids", 64'(mv), 64'(m_has_out ? pvec(m_out.port) : 3'b000));
      if (m_has_out) check("out_data", 64'(out_data), 64'(m_out.data));
      check("full", 64'(full), 64'(m_fifo.size() == DEP));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (reset_n && ((valid_l && ready_l) || (valid_r && ready_r) || (valid_s && ready_s))) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          me = sb.pop_front();
          check("sb_data", 64'(out_data), 64'(me.data));
          check("sb_port", 64'(mv), 64'(pvec(me.port)));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input int dest, input logic [1:0] src, output logic [W-1:0] msg);
    logic [AW-1:0] dv;
    logic [W-1:0]  low;
    dv  = AW'(dest);
    low = $urandom;
    msg = {dv, low[W-AW-1:0]};
    in_sig = msg;
    s = src;
    sig_alert = 1'b1;
    tick();
    sig_alert = 1'b0;
    in_sig = $urandom;
    s = 2'($urandom);
  endtask

  task automatic single(input string name, input int dest, input logic [1:0] src,
                        input logic [2:0] exp_v);
    logic [W-1:0] msg;
    push(dest, src, msg);
    @(negedge clk);
    check({name, "_e0"}, 64'({valid_l, valid_r, valid_s}), 64'd0);
    @(negedge clk);
    check(name, 64'({valid_l, valid_r, valid_s}), 64'(exp_v));
    check({name, "_data"}, 64'(out_data), 64'(msg));
    @(posedge clk);
    #1 {ready_l, ready_r, ready_s} = exp_v;
    tick();
    {ready_l, ready_r, ready_s} = 3'b000;
    @(negedge clk);
    check({name, "_idle"}, 64'({valid_l, valid_r, valid_s}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] msg;
    bit           done;
    reset_n = 1'b0;
    sig_alert = 1'b0;
    in_sig = '0;
    s = 2'b00;
    {ready_l, ready_r, ready_s} = 3'b000;
    repeat (3) tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_valids", 64'({valid_l, valid_r, valid_s}), 64'd0);
    check("rst_out", 64'(out_data), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    single("self_dest", 2, 2'b00, 3'b001);
    single("left_src", 5, 2'b00, 3'b010);
    single("right_src", 5, 2'b10, 3'b100);
    single("self_d4", 6, 2'b01, 3'b010);
    single("self_d5", 7, 2'b01, 3'b100);

    // Overflow: 4 in the FIFO plus 1 held, the sixth is dropped.
    do_reset();
    for (int i = 0; i < 6; i++) push(5, 2'b00, msg);
    @(negedge clk);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd1);
    check("ovf_valid", 64'(valid_r), 64'd1);
    @(posedge clk);
    #1 ready_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(valid_r), 64'd1);
    end
    @(negedge clk);
    check("b2b_done", 64'(valid_r), 64'd0);
    @(posedge clk);
    #1 ready_r = 1'b0;

    do_reset();
    push(0, 2'b11, msg);
    repeat (2) @(negedge clk);
    check("drop_s11", 64'(drop_cnt), 64'd1);
    check("drop_s11_v", 64'({valid_l, valid_r, valid_s}), 64'd0);
    push(9, 2'b00, msg);
    repeat (2) @(negedge clk);
    check("drop_dest9", 64'(drop_cnt), 64'd2);
    check("drop_dest9_v", 64'({valid_l, valid_r, valid_s}), 64'd0);

    do_reset();
    for (int i = 0; i < 300; i++) push(1, 2'b11, msg);
    @(negedge clk);
    check("drop_sat", 64'(drop_cnt), 64'hFF);

    // Randomized traffic with alternating stall windows.
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      logic [AW-1:0] dv;
      logic [W-1:0]  low;
      bit stall;
      stall = ((c / 100) % 3) == 1;
      dv  = AW'($urandom_range(0, 9));
      low = $urandom;
      sig_alert = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      in_sig = {dv, low[W-AW-1:0]};
      ready_l = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      ready_r = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      ready_s = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    sig_alert = 1'b0;
    {ready_l, ready_r, ready_s} = 3'b000;

    // Reset in the middle of SEND with three entries queued.
    do_reset();
    push(9, 2'b00, msg);
    for (int i = 0; i < 4; i++) push(5, 2'b00, msg);
    @(negedge clk);
    check("mid_valid", 64'(valid_r), 64'd1);
    check("mid_drop", 64'(drop_cnt), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_valids", 64'({valid_l, valid_r, valid_s}), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    check("mid_rst_out", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    {ready_l, ready_r, ready_s} = 3'b111;
    repeat (3) @(negedge clk);
    check("mid_rst_empty", 64'({valid_l, valid_r, valid_s}), 64'd0);

    // Drain whatever is left, bounded.
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !valid_l && !valid_r && !valid_s) done = 1'b1;
    end
    check("drain_timeout", 64'(done), 64'd1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
